// File: rtl/uart_status_reporter_pkg.sv
// Shared definitions for the host-link reply path: frame characters, status codes,
// counter-select range and the state encodings used by the reporter and its tx handshake.
package uart_status_reporter_pkg;

    localparam logic [7:0] ASCII_BASE_DEF = 8'h30;   // '0'
    localparam logic [7:0] STOP_CHAR_DEF  = 8'h73;   // 's', same as the host stop signal

    localparam logic [7:0] STAT_ACK     = 8'h41;     // 'A' shift finished
    localparam logic [7:0] STAT_TIMEOUT = 8'h54;     // 'T' no done pulse in time
    localparam logic [7:0] STAT_RANGE   = 8'h52;     // 'R' counter select not c0..c3

    localparam logic [2:0] C0_SEL     = 3'd2;
    localparam logic [2:0] C3_SEL     = 3'd5;
    localparam logic [2:0] FRAME_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_SEND
    } rpt_state_t;

    typedef enum logic {
        HS_LOAD,
        HS_WAIT_ACCEPT
    } hs_state_t;

    typedef struct packed {
        logic       pll;
        logic [2:0] sel;
        logic       dir;
        logic [7:0] periods;
    } shift_cmd_t;

    function automatic logic sel_in_range(input logic [2:0] sel);
        return (sel >= C0_SEL) && (sel <= C3_SEL);
    endfunction

    // Generator number 0..7 = {pll, counter}; out-of-range selects report counter 0.
    function automatic logic [7:0] gen_byte(input logic [7:0] base, input shift_cmd_t cmd);
        logic [1:0] cnt_idx;
        cnt_idx = sel_in_range(cmd.sel) ? 2'(cmd.sel - C0_SEL) : 2'b00;
        return base + {5'b00000, cmd.pll, cnt_idx};
    endfunction

endpackage

// File: rtl/uart_status_reporter_tx_handshake.sv
// Byte handshake towards the UART transmitter: raise load with a byte while tx is ready,
// hold both stable until tx drops ready (byte taken), then release. Usable by any tx source.
module uart_status_reporter_tx_handshake
    import uart_status_reporter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send_en,
    input  logic [7:0] byte_in,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       accepted
);

    hs_state_t state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HS_LOAD;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
        end else begin
            case (state_reg)
                HS_LOAD: begin
                    if (send_en && tx_ready) begin
                        tx_data   <= byte_in;
                        tx_load   <= 1'b1;
                        state_reg <= HS_WAIT_ACCEPT;
                    end
                end
                HS_WAIT_ACCEPT: begin
                    if (!tx_ready) begin
                        tx_load   <= 1'b0;
                        state_reg <= HS_LOAD;
                    end
                end
                default: begin
                    tx_load   <= 1'b0;
                    state_reg <= HS_LOAD;
                end
            endcase
        end
    end

    // Byte is taken on the cycle the transmitter drops ready while we hold load.
    assign accepted = (state_reg == HS_WAIT_ACCEPT) && !tx_ready;

endmodule

// File: rtl/uart_status_reporter.sv
// Host-link return path: latch a decoded shift command, wait for the phase shift to finish
// (or time out), then send the 5-byte reply frame status/gen/dir/periods/stop over UART tx.
module uart_status_reporter
    import uart_status_reporter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ASCII_BASE     = ASCII_BASE_DEF,
    parameter logic [7:0]  STOP_CHAR      = STOP_CHAR_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_shift_ready,
    input  logic       i_pll_to_update,
    input  logic [2:0] i_phasecounterselect,
    input  logic       i_phaseupdown,
    input  logic [7:0] i_periods_to_process,
    input  logic       i_shift_done,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_load,
    output logic       o_busy,
    output logic [7:0] o_drop_count
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    rpt_state_t         state_reg;
    shift_cmd_t         cmd_reg;
    logic [7:0]         status_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [2:0]         idx_reg;
    logic               busy_reg;
    logic [7:0]         drop_reg;

    logic [7:0] frame_byte;
    logic       send_en;
    logic       accepted;

    always_comb begin
        frame_byte = STOP_CHAR;
        case (idx_reg)
            3'd0:    frame_byte = status_reg;
            3'd1:    frame_byte = gen_byte(ASCII_BASE, cmd_reg);
            3'd2:    frame_byte = ASCII_BASE + {7'b0000000, cmd_reg.dir};
            3'd3:    frame_byte = cmd_reg.periods;
            default: frame_byte = STOP_CHAR;
        endcase
    end

    assign send_en = (state_reg == ST_SEND);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            cmd_reg    <= '0;
            status_reg <= 8'h00;
            timer_reg  <= '0;
            idx_reg    <= 3'd0;
            busy_reg   <= 1'b0;
            drop_reg   <= 8'h00;
        end else begin
            // Commands arriving outside IDLE (including the IDLE re-entry cycle) are dropped.
            if (i_shift_ready && (state_reg != ST_IDLE) && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_shift_ready) begin
                        cmd_reg   <= '{pll:     i_pll_to_update,
                                       sel:     i_phasecounterselect,
                                       dir:     i_phaseupdown,
                                       periods: i_periods_to_process};
                        busy_reg  <= 1'b1;
                        timer_reg <= '0;
                        idx_reg   <= 3'd0;
                        if (!sel_in_range(i_phasecounterselect)) begin
                            status_reg <= STAT_RANGE;
                            state_reg  <= ST_SEND;
                        end else begin
                            state_reg  <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_shift_done) begin
                        status_reg <= STAT_ACK;
                        state_reg  <= ST_SEND;
                    end else if (timer_reg == TIMER_LAST) begin
                        status_reg <= STAT_TIMEOUT;
                        state_reg  <= ST_SEND;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                ST_SEND: begin
                    if (accepted) begin
                        if (idx_reg == FRAME_LAST) begin
                            idx_reg   <= 3'd0;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    uart_status_reporter_tx_handshake u_tx_handshake (
        .clk      (i_clk),
        .rst      (i_rst),
        .send_en  (send_en),
        .byte_in  (frame_byte),
        .tx_ready (i_tx_ready),
        .tx_data  (o_tx_data),
        .tx_load  (o_tx_load),
        .accepted (accepted)
    );

    assign o_busy       = busy_reg;
    assign o_drop_count = drop_reg;

endmodule

// File: tb/tb_uart_status_reporter.sv
// Directed bench for uart_status_reporter: frames for ack/timeout/range replies, drop counting,
// tx back-pressure and mid-frame reset, with a small UART tx ready model and byte monitor.
module tb_uart_status_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic       shift_ready;
    logic       pll;
    logic [2:0] sel;
    logic       dir;
    logic [7:0] periods;
    logic       shift_done;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;
    logic [7:0] drop_count;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] got[$];
    bit         ready_block = 1'b0;
    int         hold_cnt = 0;
    int         low_cnt  = 0;
    logic       prev_load = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    uart_status_reporter #(.TIMEOUT_CYCLES(64)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_shift_ready        (shift_ready),
        .i_pll_to_update      (pll),
        .i_phasecounterselect (sel),
        .i_phaseupdown        (dir),
        .i_periods_to_process (periods),
        .i_shift_done         (shift_done),
        .i_tx_ready           (tx_ready),
        .o_tx_data            (tx_data),
        .o_tx_load            (tx_load),
        .o_busy               (busy),
        .o_drop_count         (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART tx model: takes a byte 2 cycles after load, stays busy 2 cycles, then ready again.
    always @(negedge clk) begin
        bit rise;
        if (rst) begin
            tx_ready  = 1'b1;
            hold_cnt  = 0;
            low_cnt   = 0;
            prev_load = 1'b0;
        end else begin
            rise = tx_load && !prev_load;
            if (rise) begin
                got.push_back(tx_data);
                check("load_with_ready", {31'b0, tx_ready}, 32'd1);
            end
            if (tx_load && prev_load) check("data_stable", {24'b0, tx_data}, {24'b0, prev_data});
            prev_load = tx_load;
            prev_data = tx_data;
            if (ready_block) begin
                tx_ready = 1'b0;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) begin
                    tx_ready = 1'b0;
                    low_cnt  = 2;
                end
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b1;
            end
            if (rise && !ready_block) hold_cnt = 2;
        end
    end

    task automatic send_cmd(input logic p, input logic [2:0] s, input logic d, input logic [7:0] n);
        pll = p; sel = s; dir = d; periods = n;
        shift_ready = 1'b1;
        @(negedge clk);
        shift_ready = 1'b0;
    endtask

    task automatic pulse_done();
        shift_done = 1'b1;
        @(negedge clk);
        shift_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_clear"}, {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] exp_b[5];
        logic [31:0] obs;
        exp_b = '{b0, b1, b2, b3, b4};
        check({tag, "_count"}, got.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            obs = (i < got.size()) ? {24'b0, got[i]} : 32'hDEAD;
            check($sformatf("%s_b%0d", tag, i), obs, {24'b0, exp_b[i]});
        end
        $display("frame %s: %0d bytes checked", tag, got.size());
        got.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; shift_ready = 1'b0; shift_done = 1'b0;
        pll = 1'b0; sel = 3'd0; dir = 1'b0; periods = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'b0, tx_data}, 32'h00);
        check("rst_tx_load", {31'b0, tx_load}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_drop", {24'b0, drop_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: normal ack frame
        send_cmd(1'b1, 3'd3, 1'b0, 8'd5);
        check("t1_busy", {31'b0, busy}, 32'd1);
        repeat (30) @(negedge clk);
        check("t1_no_load_before_done", {31'b0, tx_load}, 32'd0);
        pulse_done();
        wait_idle("t1", 200);
        check_frame("t1", 8'h41, 8'h35, 8'h30, 8'h05, 8'h73);
        check("t1_drop", {24'b0, drop_count}, 32'd0);

        // 2: timeout after 64 cycles
        send_cmd(1'b0, 3'd2, 1'b1, 8'd9);
        repeat (60) @(negedge clk);
        check("t2_still_waiting", got.size(), 32'd0);
        check("t2_busy", {31'b0, busy}, 32'd1);
        wait_idle("t2", 300);
        check_frame("t2", 8'h54, 8'h30, 8'h31, 8'h09, 8'h73);

        // 3: out-of-range select replies at once
        send_cmd(1'b1, 3'd7, 1'b1, 8'd200);
        repeat (2) @(negedge clk);
        check("t3_fast_load", {31'b0, tx_load}, 32'd1);
        check("t3_status", {24'b0, tx_data}, 32'h52);
        wait_idle("t3", 200);
        check_frame("t3", 8'h52, 8'h34, 8'h31, 8'hC8, 8'h73);

        // 4: commands while busy are dropped
        send_cmd(1'b0, 3'd4, 1'b0, 8'd7);
        repeat (3) begin
            @(negedge clk);
            send_cmd(1'b1, 3'd5, 1'b1, 8'd99);
        end
        repeat (5) @(negedge clk);
        pulse_done();
        wait_idle("t4", 200);
        check("t4_drop", {24'b0, drop_count}, 32'd3);
        check_frame("t4", 8'h41, 8'h32, 8'h30, 8'h07, 8'h73);

        // 5: tx held not-ready, plus drop counter saturation
        ready_block = 1'b1;
        repeat (2) @(negedge clk);
        send_cmd(1'b1, 3'd2, 1'b0, 8'd1);
        pulse_done();
        shift_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i % 100 == 50) check($sformatf("t5_no_load_%0d", i), {31'b0, tx_load}, 32'd0);
        end
        shift_ready = 1'b0;
        @(negedge clk);
        check("t5_drop_sat", {24'b0, drop_count}, 32'hFF);
        check("t5_no_bytes", got.size(), 32'd0);
        ready_block = 1'b0;
        wait_idle("t5", 200);
        check_frame("t5", 8'h41, 8'h34, 8'h30, 8'h01, 8'h73);
        check("t5_drop_hold", {24'b0, drop_count}, 32'hFF);

        // 6: reset during the third byte
        send_cmd(1'b0, 3'd5, 1'b1, 8'd3);
        pulse_done();
        n = 0;
        while (!(got.size() >= 3 && tx_load) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_third_byte", got.size(), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_load", {31'b0, tx_load}, 32'd0);
        check("t6_rst_data", {24'b0, tx_data}, 32'h00);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_drop", {24'b0, drop_count}, 32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        repeat (20) @(negedge clk);
        check("t6_no_resend", got.size(), 32'd0);
        send_cmd(1'b1, 3'd5, 1'b1, 8'd2);
        pulse_done();
        wait_idle("t6", 200);
        check_frame("t6", 8'h41, 8'h37, 8'h31, 8'h02, 8'h73);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
